// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I ALU decode slice: major-opcode constants,
// the funct3 ALU-operation enum, funct7 constants and the decoded-control
// bundle passed from alu_instr_dec to alu_decoder.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0]) handled by this slice
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    // funct7 values that are legal for the OP / OP-IMM groups
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // ALU operation, encoded exactly as funct3
    typedef enum logic [2:0] {
        ADD_SUB = 3'b000,
        SLL     = 3'b001,
        SLT     = 3'b010,
        SLTU    = 3'b011,
        XOR     = 3'b100,
        SR      = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } alu_op_e;

    // Everything the top needs from the decoder for one instruction
    typedef struct packed {
        alu_op_e         op;
        logic            is_signed;
        logic            illegal;
        logic            use_imm;     // operand2 comes from the immediate
        logic            shamt_only;  // operand2 keeps only its low 5 bits
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
    } dec_ctrl_t;

    // Shifts only ever consume a 5-bit shift amount
    function automatic logic is_shift(input alu_op_e op);
        return (op == SLL) || (op == SR);
    endfunction

endpackage

// File: rtl/alu_instr_dec.sv
// ---------------------------------------------------------------------------
// alu_instr_dec
// Purely combinational RV32I OP / OP-IMM decoder. Produces the ALU control,
// the sign-extended I-type immediate, register addresses and the illegal
// flag for one instruction word.
//
// Ports:
//   instr  in  32  instruction word
//   ctrl   out     decoded control bundle (alu_pkg::dec_ctrl_t)
// ---------------------------------------------------------------------------
module alu_instr_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_ctrl_t   ctrl
);

    logic [6:0] major;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_e    op;
    logic       legal;

    assign major  = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign op     = alu_op_e'(funct3);

    // Legality check. OP-IMM funct3 other than the shifts carries an
    // immediate in instr[31:25], so funct7 is only meaningful for shifts.
    always_comb begin
        legal = 1'b0;
        case (major)
            OP: begin
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && ((op == ADD_SUB) || (op == SR)));
            end
            OP_IMM: begin
                case (op)
                    SLL:     legal = (funct7 == FUNCT7_BASE);
                    SR:      legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Control generation. is_signed doubles as "add, not subtract" for
    // funct3 000 and as "arithmetic shift" for funct3 101. An illegal
    // instruction collapses to a harmless ADD with no destination.
    always_comb begin
        ctrl            = '0;
        ctrl.rs1_addr   = instr[19:15];
        ctrl.rs2_addr   = instr[24:20];
        ctrl.op         = op;
        ctrl.rd_addr    = instr[11:7];
        ctrl.imm        = {{20{instr[31]}}, instr[31:20]};
        ctrl.use_imm    = (major == OP_IMM);
        ctrl.shamt_only = is_shift(op);
        ctrl.illegal    = 1'b0;

        case (op)
            ADD_SUB: ctrl.is_signed = !((major == OP) && instr[30]);
            SR:      ctrl.is_signed = instr[30];
            default: ctrl.is_signed = 1'b0;
        endcase

        if (!legal) begin
            ctrl.op         = ADD_SUB;
            ctrl.is_signed  = 1'b1;
            ctrl.illegal    = 1'b1;
            ctrl.use_imm    = 1'b0;
            ctrl.shamt_only = 1'b0;
            ctrl.imm        = '0;
            ctrl.rd_addr    = '0;
        end
    end

endmodule

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// One-entry decode/issue stage between the register file and the ALU.
// Accepts an RV32I instruction, reads its sources from the register file in
// the same cycle, and presents registered ALU operands/control one cycle
// later behind a valid/ready handshake.
//
// Optional feature: define ALU_DECODER_FWD_EN to forward the writeback snoop
// port (wb_valid/wb_rd/wb_data) into the source operands. Without it the
// wb_* ports exist but are ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_instr                 instruction word
//   rs1_addr, rs2_addr       register-file read addresses (combinational)
//   rs1_data, rs2_data       register-file read data (same cycle)
//   wb_valid, wb_rd, wb_data writeback snoop
//   out_valid/out_ready      issue handshake toward the ALU
//   operand1, operand2       ALU operands (registered)
//   opcode, is_signed        ALU control (registered)
//   rd_addr, illegal         destination and illegal flag (registered)
// ---------------------------------------------------------------------------
module alu_decoder
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  opcode,
    output logic        is_signed,
    output logic [4:0]  rd_addr,
    output logic        illegal
);

    dec_ctrl_t   dec;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] next_op1;
    logic [31:0] next_op2;
    logic        in_xfer;

    alu_instr_dec u_dec (
        .instr (in_instr),
        .ctrl  (dec)
    );

    assign rs1_addr = dec.rs1_addr;
    assign rs2_addr = dec.rs2_addr;

    // The single entry can take a new instruction when empty or when it is
    // being drained in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;

    // Source selection. x0 always reads as zero; with forwarding enabled a
    // matching non-zero writeback overrides the register-file data.
    always_comb begin
        src1 = (rs1_addr == 5'd0) ? '0 : rs1_data;
        src2 = (rs2_addr == 5'd0) ? '0 : rs2_data;
`ifdef ALU_DECODER_FWD_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) begin
            src1 = wb_data;
        end
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) begin
            src2 = wb_data;
        end
`endif
    end

`ifdef ALU_DECODER_FWD_EN
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

    // Operand muxing. Shifts keep only a 5-bit amount, whether it comes
    // from rs2 or from instr[24:20] (the low bits of the immediate).
    always_comb begin
        next_op1 = src1;
        next_op2 = dec.use_imm ? dec.imm : src2;
        if (dec.shamt_only) begin
            next_op2 = {27'b0, next_op2[4:0]};
        end
        if (dec.illegal) begin
            next_op1 = '0;
            next_op2 = '0;
        end
    end

    // Output register. A new instruction always wins the entry; otherwise a
    // drain empties it. Contents are untouched while stalled, so outputs
    // hold stable. Reset discards whatever is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            operand1  <= '0;
            operand2  <= '0;
            opcode    <= 3'b000;
            is_signed <= 1'b0;
            rd_addr   <= '0;
            illegal   <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            operand1  <= next_op1;
            operand2  <= next_op2;
            opcode    <= dec.op;
            is_signed <= dec.is_signed;
            rd_addr   <= dec.rd_addr;
            illegal   <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_decoder
// Self-checking bench for alu_decoder. Expected entries are computed by a
// small reference model when an instruction is accepted and queued; the
// front of the queue is compared against the DUT outputs while valid.
// ---------------------------------------------------------------------------
module tb_alu_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  opcode;
    logic        is_signed;
    logic [4:0]  rd_addr;
    logic        illegal;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  opc;
        logic        sgn;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    alu_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .opcode    (opcode),
        .is_signed (is_signed),
        .rd_addr   (rd_addr),
        .illegal   (illegal)
    );

    // R-type and I-type encoders for the two groups under test
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Reference model of one issued entry
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] d1,
                                   input logic [31:0] d2);
        exp_t        e;
        logic [6:0]  mj;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        ok;
        mj = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        a1 = ins[19:15];
        a2 = ins[24:20];
        s1 = (a1 == 5'd0) ? 32'd0 : d1;
        s2 = (a2 == 5'd0) ? 32'd0 : d2;
`ifdef ALU_DECODER_FWD_EN
        if (wb_valid && wb_rd != 5'd0 && wb_rd == a1) s1 = wb_data;
        if (wb_valid && wb_rd != 5'd0 && wb_rd == a2) s2 = wb_data;
`endif
        if (mj == 7'b0110011)
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (mj == 7'b0010011)
            ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                 (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else
            ok = 1'b0;
        if (!ok) begin
            e = '{32'd0, 32'd0, 3'd0, 1'b1, 5'd0, 1'b1};
        end else begin
            e.op1 = s1;
            if (mj == 7'b0110011)
                e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, s2[4:0]} : s2;
            else
                e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]}
                                                  : {{20{ins[31]}}, ins[31:20]};
            e.opc = f3;
            if (f3 == 3'd0)      e.sgn = !(mj == 7'b0110011 && f7 == 7'h20);
            else if (f3 == 3'd5) e.sgn = (f7 == 7'h20);
            else                 e.sgn = 1'b0;
            e.rd  = ins[11:7];
            e.ill = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Sample mid-cycle, update the scoreboard, then advance past one edge
    task automatic tick();
        exp_t e;
        logic exp_ready;
        #3;
        exp_ready = (sb.size() == 0) || out_ready;
        checkOutput("rs1_addr", 32'(rs1_addr), 32'(in_instr[19:15]));
        checkOutput("rs2_addr", 32'(rs2_addr), 32'(in_instr[24:20]));
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            checkOutput("operand1", operand1, e.op1);
            checkOutput("operand2", operand2, e.op2);
            checkOutput("opcode", 32'(opcode), 32'(e.opc));
            checkOutput("is_signed", 32'(is_signed), 32'(e.sgn));
            checkOutput("rd_addr", 32'(rd_addr), 32'(e.rd));
            checkOutput("illegal", 32'(illegal), 32'(e.ill));
        end
        if (!rst) begin
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (in_valid && exp_ready) sb.push_back(model(in_instr, rs1_data, rs2_data));
        end
        @(posedge clk);
        if (rst) sb.delete();
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic iv, input logic ordy);
        in_instr  = ins;
        rs1_data  = d1;
        rs2_data  = d2;
        in_valid  = iv;
        out_ready = ordy;
        tick();
    endtask

    task automatic checkReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_operand1", operand1, 32'd0);
        checkOutput("rst_operand2", operand2, 32'd0);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);
        checkOutput("rst_is_signed", 32'(is_signed), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        out_ready = 1'b1;
        $display("[TB] reset");
        @(posedge clk);
        #1;
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0;
        checkReset();

        $display("[TB] directed ALU instructions");
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5), 32'd10, 32'd3, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h403, 5'd1, 3'd5, 5'd4), 32'h8000_0000, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 32'h1234, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd8, 5'd7, 3'd1, 5'd6), 32'h55, 32'hFFFF_FFE3, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h800, 5'd10, 3'd4, 5'd9), 32'h0F0F, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd12, 5'd11, 3'd3, 5'd13), 32'hFFFF_0000, 32'd1, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd0, 5'd11, 3'd2, 5'd14), 32'h8000_0001, 32'h99, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h20, 5'd15, 5'd16, 3'd5, 5'd17), 32'hF000_0000, 32'h24, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd15, 5'd16, 3'd5, 5'd18), 32'hF000_0000, 32'h24, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd20, 5'd21, 3'd6, 5'd22), 32'hA0A0, 32'h0505, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd20, 5'd21, 3'd7, 5'd23), 32'hFF00, 32'h0FF0, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h7FF, 5'd21, 3'd2, 5'd24), 32'd3, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h01F, 5'd21, 3'd1, 5'd25), 32'd3, 32'd0, 1'b1, 1'b1);

        $display("[TB] illegal instructions");
        applyStimulus(32'h0000_0073, 32'd1, 32'd2, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h403, 5'd1, 3'd1, 5'd4), 32'd8, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd3), 32'd8, 32'd9, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'd8, 32'd9, 1'b1, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        $display("[TB] stall and release");
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd100, 32'd200, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd5), 32'd11, 32'd22, 1'b1, 1'b0);
        applyStimulus(enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd5), 32'd11, 32'd22, 1'b1, 1'b0);
        applyStimulus(enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd5), 32'd11, 32'd22, 1'b1, 1'b0);
        applyStimulus(enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd5), 32'd11, 32'd22, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h005, 5'd3, 3'd0, 5'd6), 32'd40, 32'd0, 1'b1, 1'b1);
        applyStimulus(enc_i(12'h00A, 5'd3, 3'd6, 5'd7), 32'd41, 32'd0, 1'b1, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        $display("[TB] reset during stall");
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd8), 32'hF0, 32'h3C, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'hF0, 32'h3C, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'hF0, 32'h3C, 1'b1, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0;
        checkReset();

        $display("[TB] writeback snoop");
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'd9;
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1, 1'b1);
        applyStimulus(enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3), 32'd6, 32'd5, 1'b1, 1'b1);
        wb_rd = 5'd0;
        applyStimulus(enc_i(12'h005, 5'd0, 3'd0, 5'd2), 32'h55, 32'd0, 1'b1, 1'b1);
        wb_valid = 1'b0;
        wb_rd    = 5'd1;
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
